csr_irq_file: RTL

Parametrised machine-mode CSR file for the OTTER RISC-V core. It supports multiple interrupt lines, pending-interrupt latching with fixed priority, MIE/MPIE stacking on trap entry and on `mret`, and direct or vectored trap-vector generation. It sits beside the control unit: it raises `INT_REQ`, the control unit answers with `INT_TAKEN` or `MRET`, and the PC mux takes `TRAP_VEC` or `CSR_MEPC`.

---
 rtl/csr_irq_file.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_irq_file.sv
// ---------------------------------------------------------------------------
// csr_irq_file
// Machine-mode CSR file for the OTTER RISC-V core. Latches rising edges on
// the external interrupt lines into mip, selects the highest-priority
// enabled pending line, stacks MIE/MPIE on trap entry and mret, and builds
// the direct or vectored trap target.
//
// Parameters:
//   NUM_IRQ   number of external interrupt lines (1..16); line i uses
//             cause code 16+i and mie/mip bit 16+i
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   IRQ        interrupt lines (synchronous to CLK, rising-edge sensitive)
//   INT_TAKEN  control unit enters the trap this cycle
//   MRET       an mret retires this cycle
//   ADDR       CSR address for read and write
//   WD         CSR write data (already resolved for csrrw/csrrs/csrrc)
//   WR_EN      CSR write strobe
//   PC         PC of the interrupted instruction
//   RD         combinational read data for ADDR
//   CSR_MEPC   return address
//   TRAP_VEC   trap target for the selected interrupt
//   INT_REQ    interrupt request to the control unit
// ---------------------------------------------------------------------------
module csr_irq_file #(
    parameter int NUM_IRQ = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               INT_TAKEN,
    input  logic               MRET,
    input  logic [11:0]        ADDR,
    input  logic [31:0]        WD,
    input  logic               WR_EN,
    input  logic [31:0]        PC,
    output logic [31:0]        RD,
    output logic [31:0]        CSR_MEPC,
    output logic [31:0]        TRAP_VEC,
    output logic               INT_REQ
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    // Architectural state
    logic               mstatus_mie_r;
    logic               mstatus_mpie_r;
    logic [NUM_IRQ-1:0] mie_en_r;
    logic [29:0]        mtvec_base_r;
    logic               mtvec_vec_r;     // 1 = vectored, 0 = direct
    logic [31:0]        mepc_r;          // bits [1:0] always written as 0
    logic               mcause_int_r;
    logic [4:0]         mcause_code_r;
    logic [NUM_IRQ-1:0] mip_r;
    logic [NUM_IRQ-1:0] irq_q_r;

    // Derived signals
    logic [NUM_IRQ-1:0] pend_en_s;
    logic [NUM_IRQ-1:0] irq_edge_s;
    logic [NUM_IRQ-1:0] take_mask_s;
    logic [3:0]         sel_s;
    logic               found_s;
    logic               any_pend_s;
    logic               int_req_s;
    logic               take_s;
    logic [4:0]         code_s;
    logic [31:0]        base_s;
    logic [31:0]        rd_mie_s;
    logic [31:0]        rd_mip_s;

    assign pend_en_s  = mip_r & mie_en_r;
    assign irq_edge_s = IRQ & ~irq_q_r;
    assign any_pend_s = |pend_en_s;
    assign int_req_s  = mstatus_mie_r & any_pend_s;
    // A take request with nothing to take is ignored.
    assign take_s     = INT_TAKEN & int_req_s;
    assign code_s     = 5'd16 + {1'b0, sel_s};
    assign base_s     = {mtvec_base_r, 2'b00};

    // Fixed-priority select: the lowest enabled pending index wins.
    always_comb begin
        sel_s   = 4'd0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend_en_s[i] && !found_s) begin
                sel_s   = 4'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot mask of the line being taken this cycle (all zero if none).
    always_comb begin
        take_mask_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            take_mask_s[i] = take_s && (sel_s == 4'(i));
        end
    end

    // Trap target: vectored offset applies only while a request is live.
    always_comb begin
        if (int_req_s && mtvec_vec_r) begin
            TRAP_VEC = base_s + {25'd0, code_s, 2'b00};
        end else begin
            TRAP_VEC = base_s;
        end
    end

    // Place the per-line mie/mip bits at their architectural positions.
    always_comb begin
        rd_mie_s = 32'd0;
        rd_mip_s = 32'd0;
        rd_mie_s[16 +: NUM_IRQ] = mie_en_r;
        rd_mip_s[16 +: NUM_IRQ] = mip_r;
    end

    // CSR read mux; unmapped addresses read as zero.
    always_comb begin
        case (ADDR)
            ADDR_MSTATUS: RD = {24'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
            ADDR_MIE:     RD = rd_mie_s;
            ADDR_MTVEC:   RD = {mtvec_base_r, 1'b0, mtvec_vec_r};
            ADDR_MEPC:    RD = mepc_r;
            ADDR_MCAUSE:  RD = {mcause_int_r, 26'd0, mcause_code_r};
            ADDR_MIP:     RD = rd_mip_s;
            default:      RD = 32'd0;
        endcase
    end

    assign CSR_MEPC = mepc_r;
    assign INT_REQ  = int_req_s;

    // State update: trap entry beats mret, mret beats a CSR write, per field.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_en_r       <= '0;
            mtvec_base_r   <= 30'd0;
            mtvec_vec_r    <= 1'b0;
            mepc_r         <= 32'd0;
            mcause_int_r   <= 1'b0;
            mcause_code_r  <= 5'd0;
            mip_r          <= '0;
            irq_q_r        <= '0;
        end else begin
            irq_q_r <= IRQ;
            // A fresh edge on the line being taken keeps its pending bit set.
            mip_r   <= (mip_r & ~take_mask_s) | irq_edge_s;

            if (take_s) begin
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (MRET) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end else if (WR_EN && (ADDR == ADDR_MSTATUS)) begin
                mstatus_mie_r  <= WD[3];
                mstatus_mpie_r <= WD[7];
            end else begin
                mstatus_mie_r  <= mstatus_mie_r;
                mstatus_mpie_r <= mstatus_mpie_r;
            end

            if (take_s) begin
                mepc_r <= PC & 32'hFFFF_FFFC;
            end else if (WR_EN && (ADDR == ADDR_MEPC)) begin
                mepc_r <= WD & 32'hFFFF_FFFC;
            end else begin
                mepc_r <= mepc_r;
            end

            if (take_s) begin
                mcause_int_r  <= 1'b1;
                mcause_code_r <= code_s;
            end else if (WR_EN && (ADDR == ADDR_MCAUSE)) begin
                mcause_int_r  <= WD[31];
                mcause_code_r <= WD[4:0];
            end else begin
                mcause_int_r  <= mcause_int_r;
                mcause_code_r <= mcause_code_r;
            end

            if (WR_EN && (ADDR == ADDR_MIE)) begin
                mie_en_r <= WD[16 +: NUM_IRQ];
            end else begin
                mie_en_r <= mie_en_r;
            end

            // Reserved MODE encodings 2 and 3 store as direct.
            if (WR_EN && (ADDR == ADDR_MTVEC)) begin
                mtvec_base_r <= WD[31:2];
                mtvec_vec_r  <= (WD[1:0] == 2'b01);
            end else begin
                mtvec_base_r <= mtvec_base_r;
                mtvec_vec_r  <= mtvec_vec_r;
            end
        end
    end

endmodule
